// File: rtl/cci_memcpy_copy_engine.sv
// Line-granular CCI-P copy engine: streams lines from buf_addr on c0 and writes them to bufcpy_addr on c1.
// Define MEMCPY_CYCLE_CNT_EN to add the cycle_cnt port (cycles spent in RUN).

package ccip_if_pkg;
  typedef logic [41:0]  t_ccip_clAddr;
  typedef logic [15:0]  t_ccip_mdata;
  typedef logic [511:0] t_ccip_clData;
  typedef logic [1:0]   t_ccip_clNum;

  typedef enum logic [1:0] {eVC_VA = 2'h0, eVC_VL0 = 2'h1, eVC_VH0 = 2'h2, eVC_VH1 = 2'h3} t_ccip_vc;
  typedef enum logic [1:0] {eCL_LEN_1 = 2'h0, eCL_LEN_2 = 2'h1, eCL_LEN_4 = 2'h3} t_ccip_clLen;
  typedef enum logic [3:0] {eREQ_RDLINE_I = 4'h0, eREQ_RDLINE_S = 4'h1} t_ccip_c0_req;
  typedef enum logic [3:0] {eREQ_WRLINE_I = 4'h0, eREQ_WRLINE_M = 4'h1, eREQ_WRPUSH_I = 4'h2,
                            eREQ_WRFENCE = 4'h4, eREQ_INTR = 4'h6} t_ccip_c1_req;
  typedef enum logic [3:0] {eRSP_RDLINE = 4'h0, eRSP_UMSG = 4'h4} t_ccip_c0_rsp;
  typedef enum logic [3:0] {eRSP_WRLINE = 4'h0, eRSP_WRFENCE = 4'h4, eRSP_INTR = 4'h6} t_ccip_c1_rsp;

  typedef struct packed {
    t_ccip_vc vc_sel; t_ccip_clLen cl_len; t_ccip_c0_req req_type;
    t_ccip_clAddr address; t_ccip_mdata mdata;
  } t_ccip_c0_ReqMemHdr;
  typedef struct packed {
    t_ccip_vc vc_sel; logic sop; t_ccip_clLen cl_len; t_ccip_c1_req req_type;
    t_ccip_clAddr address; t_ccip_mdata mdata;
  } t_ccip_c1_ReqMemHdr;
  typedef struct packed {
    t_ccip_vc vc_used; logic hit_miss; t_ccip_clNum cl_num; t_ccip_c0_rsp resp_type; t_ccip_mdata mdata;
  } t_ccip_c0_RspMemHdr;
  typedef struct packed {
    t_ccip_vc vc_used; logic hit_miss; logic format; t_ccip_clNum cl_num;
    t_ccip_c1_rsp resp_type; t_ccip_mdata mdata;
  } t_ccip_c1_RspMemHdr;

  typedef struct packed { t_ccip_c0_ReqMemHdr hdr; logic valid; } t_if_ccip_c0_Tx;
  typedef struct packed { t_ccip_c1_ReqMemHdr hdr; t_ccip_clData data; logic valid; } t_if_ccip_c1_Tx;
  typedef struct packed {
    t_ccip_c0_RspMemHdr hdr; t_ccip_clData data; logic rspValid; logic mmioRdValid; logic mmioWrValid;
  } t_if_ccip_c0_Rx;
  typedef struct packed { t_ccip_c1_RspMemHdr hdr; logic rspValid; } t_if_ccip_c1_Rx;
  typedef struct packed {
    logic c0TxAlmFull; logic c1TxAlmFull; t_if_ccip_c0_Rx c0; t_if_ccip_c1_Rx c1;
  } t_if_ccip_Rx;
endpackage

// state | meaning
// IDLE  | waiting for start; no requests issued
// RUN   | issuing reads, buffering responses, issuing writes, counting write acks
// DONE  | all writes acknowledged; finished held until the next accepted start
module cci_memcpy_copy_engine
  import ccip_if_pkg::*;
#(
  parameter int SIZE_W     = 16,
  parameter int FIFO_DEPTH = 64
) (
  input  logic               clk,
  input  logic               soft_reset,
  input  logic               start,
  input  logic [SIZE_W-1:0]  size,
  input  t_ccip_clAddr       buf_addr,
  input  t_ccip_clAddr       bufcpy_addr,
  input  t_if_ccip_Rx        sRx,
  output t_if_ccip_c0_Tx     sTx_c0,
  output t_if_ccip_c1_Tx     sTx_c1,
`ifdef MEMCPY_CYCLE_CNT_EN
  output logic [63:0]        cycle_cnt,
`endif
  output logic               busy,
  output logic               finished
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [SIZE_W:0] DEPTH_L = (SIZE_W+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, RUN, DONE} t_state;
  t_state state;

  logic [SIZE_W-1:0] sizeQ, rdCnt, wrCnt, inFlight;
  logic [SIZE_W:0]   wrRspCnt;
  t_ccip_clAddr      bufAddrQ, bufcpyAddrQ;
  logic [AW:0]       wrPtr, rdPtr;
  t_ccip_mdata       fifoIdx  [FIFO_DEPTH];
  t_ccip_clData      fifoData [FIFO_DEPTH];

  logic        fifoEmpty, push, pop, rdIssue, wrRsp, accept;
  logic [2:0]  wrRspInc;
  t_ccip_mdata popIdx;
  logic        unusedRx;

  assign inFlight  = rdCnt - wrCnt;
  assign fifoEmpty = (wrPtr == rdPtr);
  assign accept    = (state != RUN) && start;
  assign push      = (state == RUN) && sRx.c0.rspValid && (sRx.c0.hdr.resp_type == eRSP_RDLINE);
  assign pop       = (state == RUN) && !fifoEmpty && !sRx.c1TxAlmFull;
  // Read credits are bounded by buffer depth so a push can never find the buffer full.
  assign rdIssue   = (state == RUN) && (rdCnt < sizeQ) && !sRx.c0TxAlmFull
                     && ({1'b0, inFlight} < DEPTH_L);
  assign wrRsp     = (state == RUN) && sRx.c1.rspValid && (sRx.c1.hdr.resp_type == eRSP_WRLINE);
  assign wrRspInc  = sRx.c1.hdr.format ? ({1'b0, sRx.c1.hdr.cl_num} + 3'd1) : 3'd1;
  assign popIdx    = fifoIdx[rdPtr[AW-1:0]];

  assign unusedRx  = ^{sRx.c0.mmioRdValid, sRx.c0.mmioWrValid, sRx.c0.hdr.vc_used, sRx.c0.hdr.hit_miss,
                       sRx.c0.hdr.cl_num, sRx.c1.hdr.vc_used, sRx.c1.hdr.hit_miss, sRx.c1.hdr.mdata};

  always_ff @(posedge clk) begin
    if (push) begin
      fifoIdx[wrPtr[AW-1:0]]  <= sRx.c0.hdr.mdata;
      fifoData[wrPtr[AW-1:0]] <= sRx.c0.data;
    end
  end

  always_ff @(posedge clk or posedge soft_reset) begin
    if (soft_reset) begin
      state       <= IDLE;
      busy        <= 1'b0;
      finished    <= 1'b0;
      sizeQ       <= '0;
      bufAddrQ    <= '0;
      bufcpyAddrQ <= '0;
      rdCnt       <= '0;
      wrCnt       <= '0;
      wrRspCnt    <= '0;
      wrPtr       <= '0;
      rdPtr       <= '0;
      sTx_c0      <= '0;
      sTx_c1      <= '0;
    end else begin
      sTx_c0.valid <= 1'b0;
      sTx_c1.valid <= 1'b0;

      case (state)
        IDLE, DONE: begin
          if (start) begin
            sizeQ       <= size;
            bufAddrQ    <= buf_addr;
            bufcpyAddrQ <= bufcpy_addr;
            rdCnt       <= '0;
            wrCnt       <= '0;
            wrRspCnt    <= '0;
            wrPtr       <= '0;
            rdPtr       <= '0;
            if (size != '0) begin
              state    <= RUN;
              busy     <= 1'b1;
              finished <= 1'b0;
            end else begin
              state    <= IDLE;
              finished <= 1'b1;
            end
          end
        end
        RUN: begin
          if (wrRspCnt == {1'b0, sizeQ}) begin
            state    <= DONE;
            busy     <= 1'b0;
            finished <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase

      if (rdIssue) begin
        sTx_c0.valid        <= 1'b1;
        sTx_c0.hdr.vc_sel   <= eVC_VA;
        sTx_c0.hdr.cl_len   <= eCL_LEN_1;
        sTx_c0.hdr.req_type <= eREQ_RDLINE_I;
        sTx_c0.hdr.address  <= bufAddrQ + 42'(rdCnt);
        sTx_c0.hdr.mdata    <= 16'(rdCnt);
        rdCnt               <= rdCnt + 1'b1;
      end

      if (push) wrPtr <= wrPtr + 1'b1;

      // Each buffered line carries its own index, so out-of-order returns need no reordering.
      if (pop) begin
        sTx_c1.valid        <= 1'b1;
        sTx_c1.hdr.vc_sel   <= eVC_VA;
        sTx_c1.hdr.sop      <= 1'b1;
        sTx_c1.hdr.cl_len   <= eCL_LEN_1;
        sTx_c1.hdr.req_type <= eREQ_WRLINE_I;
        sTx_c1.hdr.address  <= bufcpyAddrQ + 42'(popIdx);
        sTx_c1.hdr.mdata    <= popIdx;
        sTx_c1.data         <= fifoData[rdPtr[AW-1:0]];
        rdPtr               <= rdPtr + 1'b1;
        wrCnt               <= wrCnt + 1'b1;
      end

      if (wrRsp) wrRspCnt <= wrRspCnt + (SIZE_W+1)'(wrRspInc);
    end
  end

`ifdef MEMCPY_CYCLE_CNT_EN
  always_ff @(posedge clk or posedge soft_reset) begin
    if (soft_reset)          cycle_cnt <= '0;
    else if (accept)         cycle_cnt <= '0;
    else if (state == RUN)   cycle_cnt <= cycle_cnt + 64'd1;
  end
`endif

endmodule
